// File: rtl/rif_csr_pkg.sv
// Shared definitions for the RIF CSR/timer block: register offsets,
// CTRL bit positions, the register decode enum and small helpers.
package rif_csr_pkg;

   localparam logic [31:0] OFF_ID       = 32'h00;
   localparam logic [31:0] OFF_CTRL     = 32'h04;
   localparam logic [31:0] OFF_SCRATCH  = 32'h08;
   localparam logic [31:0] OFF_EVT      = 32'h0C;
   localparam logic [31:0] OFF_STATUS   = 32'h10;
   localparam logic [31:0] OFF_ENABLE   = 32'h14;
   localparam logic [31:0] OFF_PRESCALE = 32'h18;
   localparam logic [31:0] OFF_LOAD     = 32'h1C;
   localparam logic [31:0] OFF_COUNT    = 32'h20;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_RELOAD   = 1;
   localparam int IRQ_TIMER_BIT = 31;

   typedef enum logic [3:0] {
      REG_ID,
      REG_CTRL,
      REG_SCRATCH,
      REG_EVT,
      REG_STATUS,
      REG_ENABLE,
      REG_PRESCALE,
      REG_LOAD,
      REG_COUNT,
      REG_NONE
   } reg_e;

   // Word-aligned decode: bits [1:0] are ignored, all upper bits must match.
   function automatic reg_e addr_decode(input logic [31:0] addr);
      logic [29:0] w;
      reg_e        r;
      w = addr[31:2];
      unique case (1'b1)
         (w == OFF_ID[31:2]):       r = REG_ID;
         (w == OFF_CTRL[31:2]):     r = REG_CTRL;
         (w == OFF_SCRATCH[31:2]):  r = REG_SCRATCH;
         (w == OFF_EVT[31:2]):      r = REG_EVT;
         (w == OFF_STATUS[31:2]):   r = REG_STATUS;
         (w == OFF_ENABLE[31:2]):   r = REG_ENABLE;
         (w == OFF_PRESCALE[31:2]): r = REG_PRESCALE;
         (w == OFF_LOAD[31:2]):     r = REG_LOAD;
         (w == OFF_COUNT[31:2]):    r = REG_COUNT;
         default:                   r = REG_NONE;
      endcase
      return r;
   endfunction

   // Expands byte strobes into a bit mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/rif_csr_timer.sv
// Prescaled down-counter. Ports: aclk/aresetn, en, reload, prescale,
// load_val/load_stb (count load), psc_clr, count, expire, hw_clr_en.
module rif_csr_timer
   import rif_csr_pkg::*;
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        en,
   input  logic        reload,
   input  logic [15:0] prescale,
   input  logic [31:0] load_val,
   input  logic        load_stb,
   input  logic        psc_clr,
   output logic [31:0] count,
   output logic        expire,
   output logic        hw_clr_en
);

   logic [15:0] psc;
   logic        wrap;

   assign wrap      = en & (psc == prescale);
   assign expire    = wrap & (count == '0);
   assign hw_clr_en = expire & ~reload;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         psc   <= '0;
         count <= '0;
      end else if (load_stb) begin
         // load_val already carries the new value, so it also
         // serves a coincident expiry reload
         count <= load_val;
         psc   <= '0;
      end else if (en) begin
         if (wrap) begin
            psc <= '0;
            if (count != '0) begin
               count <= count - 32'd1;
            end else if (reload) begin
               count <= load_val;
            end
         end else begin
            psc <= psc + 16'd1;
         end
      end else if (psc_clr) begin
         psc <= '0;
      end
   end

endmodule

// File: rtl/rif_csr_timer_block.sv
// RIF CSR slave: ID, CTRL, SCRATCH, EVT_LEVEL, W1C IRQ status/enable,
// prescaled timer. Ports: aclk, aresetn, rif_w*/rif_r* request channels
// with combinational wvalid/rvalid/rdata, event_in, irq, timer_tick.
// Option: RIF_CSR_EVENT_SYNC_EN adds a 2-flop event_in synchronizer.
module rif_csr_timer_block
   import rif_csr_pkg::*;
#(
   parameter int          AXI_ADDR_WIDTH = 12,
   parameter int          AXI_DATA_WIDTH = 32,
   parameter int          AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8,
   parameter int          NUM_EVENTS     = 4,
   parameter logic [31:0] ID_VALUE       = 32'h5249_4601
)(
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0] rif_waddr,
   input  logic                      rif_wr_req,
   input  logic [AXI_BYTE_COUNT-1:0] rif_wstrb,
   input  logic [AXI_DATA_WIDTH-1:0] rif_wdata,
   output logic                      rif_wvalid,
   input  logic [AXI_ADDR_WIDTH-1:0] rif_raddr,
   input  logic                      rif_rd_req,
   output logic                      rif_rvalid,
   output logic [AXI_DATA_WIDTH-1:0] rif_rdata,
   input  logic [NUM_EVENTS-1:0]     event_in,
   output logic                      irq,
   output logic                      timer_tick
);

   if (AXI_DATA_WIDTH != 32) begin : g_dw_chk
      $fatal(1, "rif_csr_timer_block: AXI_DATA_WIDTH must be 32");
   end
   if (NUM_EVENTS < 1 || NUM_EVENTS > 31) begin : g_ne_chk
      $fatal(1, "rif_csr_timer_block: NUM_EVENTS must be 1..31");
   end

   localparam logic [31:0] EVT_MASK =
      32'((64'h1 << NUM_EVENTS) - 64'h1);
   localparam logic [31:0] IRQ_MASK =
      EVT_MASK | (32'h1 << IRQ_TIMER_BIT);

   logic [1:0]            ctrl;
   logic [31:0]           scratch;
   logic [31:0]           irq_status;
   logic [31:0]           irq_enable;
   logic [15:0]           prescale;
   logic [31:0]           timer_load;
   logic [NUM_EVENTS-1:0] ev_src;
   logic [NUM_EVENTS-1:0] ev_q;

   reg_e        wsel;
   reg_e        rsel;
   logic        wr_en;
   logic [31:0] wmask;
   logic [31:0] wbits;
   logic [31:0] ctrl_new;
   logic [31:0] load_new;
   logic [31:0] load_val;
   logic [31:0] w1c;
   logic [31:0] irq_set;
   logic [31:0] count;
   logic        expire;
   logic        hw_clr_en;
   logic        psc_clr;
   logic        unused;

   assign unused = rif_rd_req;

`ifdef RIF_CSR_EVENT_SYNC_EN
   logic [NUM_EVENTS-1:0] ev_s1;
   logic [NUM_EVENTS-1:0] ev_s2;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ev_s1 <= '0;
         ev_s2 <= '0;
      end else begin
         ev_s1 <= event_in;
         ev_s2 <= ev_s1;
      end
   end

   assign ev_src = ev_s2;
`else
   assign ev_src = event_in;
`endif

   assign wsel = addr_decode(32'(rif_waddr));
   assign rsel = addr_decode(32'(rif_raddr));

   assign rif_wvalid = wsel inside {REG_CTRL, REG_SCRATCH, REG_STATUS,
                                    REG_ENABLE, REG_PRESCALE, REG_LOAD};
   assign rif_rvalid = (rsel != REG_NONE);
   assign wr_en      = rif_wr_req & rif_wvalid;

   assign wmask    = strb_mask(rif_wstrb);
   assign wbits    = rif_wdata & wmask;
   assign ctrl_new = ({30'b0, ctrl} & ~wmask) | wbits;
   assign load_new = (timer_load & ~wmask) | wbits;
   assign load_val = (wr_en && wsel == REG_LOAD) ? load_new : timer_load;

   // Prescaler restarts only on a genuine EN 0->1 transition.
   assign psc_clr = wr_en && wsel == REG_CTRL &&
                    ctrl_new[CTRL_EN] && !ctrl[CTRL_EN];

   assign w1c     = (wr_en && wsel == REG_STATUS) ? wbits : '0;
   assign irq_set = 32'(ev_src & ~ev_q) |
                    (32'(expire) << IRQ_TIMER_BIT);

   rif_csr_timer u_timer (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .en        (ctrl[CTRL_EN]),
      .reload    (ctrl[CTRL_RELOAD]),
      .prescale  (prescale),
      .load_val  (load_val),
      .load_stb  (wr_en && wsel == REG_LOAD),
      .psc_clr   (psc_clr),
      .count     (count),
      .expire    (expire),
      .hw_clr_en (hw_clr_en)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ctrl       <= '0;
         scratch    <= '0;
         irq_status <= '0;
         irq_enable <= '0;
         prescale   <= '0;
         timer_load <= '0;
         ev_q       <= '0;
         irq        <= 1'b0;
         timer_tick <= 1'b0;
      end else begin
         // software CTRL write wins over the expiry auto-clear
         if (wr_en && wsel == REG_CTRL) begin
            ctrl <= ctrl_new[1:0];
         end else if (hw_clr_en) begin
            ctrl[CTRL_EN] <= 1'b0;
         end
         if (wr_en && wsel == REG_SCRATCH) begin
            scratch <= (scratch & ~wmask) | wbits;
         end
         if (wr_en && wsel == REG_ENABLE) begin
            irq_enable <= ((irq_enable & ~wmask) | wbits) & IRQ_MASK;
         end
         if (wr_en && wsel == REG_PRESCALE) begin
            prescale <= (prescale & ~wmask[15:0]) | wbits[15:0];
         end
         if (wr_en && wsel == REG_LOAD) begin
            timer_load <= load_new;
         end
         // set applied after clear so a coincident edge survives
         irq_status <= ((irq_status & ~w1c) | irq_set) & IRQ_MASK;
         ev_q       <= ev_src;
         irq        <= |(irq_status & irq_enable);
         timer_tick <= expire;
      end
   end

   always_comb begin
      rif_rdata = '0;
      unique case (rsel)
         REG_ID:       rif_rdata = ID_VALUE;
         REG_CTRL:     rif_rdata = {30'b0, ctrl};
         REG_SCRATCH:  rif_rdata = scratch;
         REG_EVT:      rif_rdata = 32'(ev_src);
         REG_STATUS:   rif_rdata = irq_status;
         REG_ENABLE:   rif_rdata = irq_enable;
         REG_PRESCALE: rif_rdata = {16'b0, prescale};
         REG_LOAD:     rif_rdata = timer_load;
         REG_COUNT:    rif_rdata = count;
         default:      rif_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_rif_csr_timer_block.sv
// Bench for rif_csr_timer_block: directed register/event/timer cases,
// then randomized traffic compared every cycle against a reference model.
module tb_rif_csr_timer_block;

   localparam logic [31:0] MASK = 32'h8000_000F;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [11:0] waddr = '0;
   logic        wr_req = 1'b0;
   logic [3:0]  wstrb = '0;
   logic [31:0] wdata = '0;
   logic        rif_wvalid;
   logic [11:0] raddr = '0;
   logic        rd_req = 1'b0;
   logic        rif_rvalid;
   logic [31:0] rif_rdata;
   logic [3:0]  event_in = '0;
   logic        irq;
   logic        timer_tick;

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 1'b0;

   // reference model state
   logic        m_en, m_rl;
   logic [31:0] m_scr, m_stat, m_ien, m_load, m_cnt;
   logic [15:0] m_psc, m_ph;
   logic [3:0]  m_evp;
   logic        m_irq, m_tick;

   always #5 aclk = ~aclk;

   rif_csr_timer_block dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .rif_waddr  (waddr),
      .rif_wr_req (wr_req),
      .rif_wstrb  (wstrb),
      .rif_wdata  (wdata),
      .rif_wvalid (rif_wvalid),
      .rif_raddr  (raddr),
      .rif_rd_req (rd_req),
      .rif_rvalid (rif_rvalid),
      .rif_rdata  (rif_rdata),
      .event_in   (event_in),
      .irq        (irq),
      .timer_tick (timer_tick)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic m_wvalid(input logic [11:0] a);
      return a[11:2] inside {10'd1, 10'd2, 10'd4, 10'd5, 10'd6, 10'd7};
   endfunction

   // {valid, data} the map must return for a read of address a
   function automatic logic [32:0] m_read(input logic [11:0] a);
      case (a[11:2])
         10'd0:   return {1'b1, 32'h5249_4601};
         10'd1:   return {1'b1, 30'b0, m_rl, m_en};
         10'd2:   return {1'b1, m_scr};
         10'd3:   return {1'b1, 28'b0, event_in};
         10'd4:   return {1'b1, m_stat};
         10'd5:   return {1'b1, m_ien};
         10'd6:   return {1'b1, 16'b0, m_psc};
         10'd7:   return {1'b1, m_load};
         10'd8:   return {1'b1, m_cnt};
         default: return 33'b0;
      endcase
   endfunction

   always @(posedge aclk) begin : model
      logic [31:0] bm, wv, nl, nc, ns;
      logic [15:0] np;
      logic [9:0]  w;
      logic        wr, wrap, ex, en2, rl2;
      if (!aresetn) begin
         m_en <= 0; m_rl <= 0; m_scr <= 0; m_stat <= 0; m_ien <= 0;
         m_psc <= 0; m_load <= 0; m_cnt <= 0; m_ph <= 0; m_evp <= 0;
         m_irq <= 0; m_tick <= 0;
      end else begin
         w  = waddr[11:2];
         wr = wr_req && m_wvalid(waddr);
         for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{wstrb[i]}};
         wv = wdata & bm;
         nl = (wr && w == 7) ? ((m_load & ~bm) | wv) : m_load;
         // the timer expires when the phase reaches PRESCALE at count 0
         wrap = m_en && (m_ph == m_psc);
         ex   = wrap && (m_cnt == 0);
         nc = m_cnt;
         np = m_ph;
         if (wr && w == 7) begin
            nc = nl;
            np = 0;
         end else if (wrap) begin
            np = 0;
            if (m_cnt != 0) nc = m_cnt - 1;
            else if (m_rl) nc = nl;
         end else if (m_en) begin
            np = m_ph + 1;
         end else if (wr && w == 1 && wstrb[0] && wdata[0]) begin
            np = 0;
         end
         en2 = m_en;
         rl2 = m_rl;
         if (wr && w == 1) begin
            if (wstrb[0]) {rl2, en2} = wdata[1:0];
         end else if (ex && !m_rl) begin
            en2 = 0;
         end
         ns = m_stat & ~((wr && w == 4) ? wv : 32'h0);
         ns = ns | {28'b0, event_in & ~m_evp};
         if (ex) ns[31] = 1'b1;
         m_stat <= ns & MASK;
         if (wr && w == 2) m_scr <= (m_scr & ~bm) | wv;
         if (wr && w == 5) m_ien <= ((m_ien & ~bm) | wv) & MASK;
         if (wr && w == 6) m_psc <= (m_psc & ~bm[15:0]) | wv[15:0];
         m_load <= nl;
         m_cnt  <= nc;
         m_ph   <= np;
         m_en   <= en2;
         m_rl   <= rl2;
         m_evp  <= event_in;
         m_irq  <= |(m_stat & m_ien);
         m_tick <= ex;
      end
   end

   always @(negedge aclk) begin : compare
      logic [32:0] e;
      if (chk_on) begin
         e = m_read(raddr);
         chk("rvalid", 32'(rif_rvalid), 32'(e[32]));
         chk("rdata", rif_rdata, e[31:0]);
         chk("wvalid", 32'(rif_wvalid), 32'(m_wvalid(waddr)));
         chk("irq", 32'(irq), 32'(m_irq));
         chk("timer_tick", 32'(timer_tick), 32'(m_tick));
      end
   end

   task automatic cycle();
      @(posedge aclk);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      waddr  = a;
      wdata  = d;
      wstrb  = s;
      wr_req = 1'b1;
      cycle();
      wr_req = 1'b0;
   endtask

   task automatic peek(input logic [11:0] a, input logic [31:0] exp,
                       input string nm);
      raddr = a;
      #1;
      chk(nm, rif_rdata, exp);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (n < 40) begin
         cycle();
         n++;
         if (timer_tick) break;
      end
   endtask

   initial begin
      int n;
      logic acc;
      logic [11:0] a;
      cycle();
      chk_on  = 1'b1;
      aresetn = 1'b1;

      // reset state and decode
      peek(12'h000, 32'h5249_4601, "id_rdata");
      chk("id_rvalid", 32'(rif_rvalid), 32'd1);
      peek(12'h024, 32'h0, "unmapped_rdata");
      chk("unmapped_rvalid", 32'(rif_rvalid), 32'd0);
      cycle();
      peek(12'h004, 32'h0, "ctrl_reset");
      chk("irq_reset", 32'(irq), 32'd0);
      waddr  = 12'h00C;
      wdata  = 32'hFFFF_FFFF;
      wstrb  = 4'hF;
      wr_req = 1'b1;
      #1;
      chk("evt_wvalid", 32'(rif_wvalid), 32'd0);
      cycle();
      wr_req = 1'b0;
      peek(12'h00C, 32'h0, "evt_unchanged");

      // byte strobes
      wr(12'h008, 32'hFFFF_FFFF, 4'b0101);
      peek(12'h008, 32'h00FF_00FF, "scratch_strb");

      // event edge, W1C, coincident set/clear
      wr(12'h014, 32'h4, 4'hF);
      event_in = 4'b0100;
      cycle();
      peek(12'h010, 32'h4, "evt_status");
      chk("irq_lag", 32'(irq), 32'd0);
      cycle();
      chk("irq_set", 32'(irq), 32'd1);
      wr(12'h010, 32'h4, 4'hF);
      peek(12'h010, 32'h0, "w1c_status");
      cycle();
      chk("irq_drop", 32'(irq), 32'd0);
      event_in = 4'b0000;
      cycle();
      event_in = 4'b0100;
      wr(12'h010, 32'h4, 4'hF);
      peek(12'h010, 32'h4, "set_beats_clear");
      wr(12'h010, 32'h4, 4'hF);

      // one-shot timer
      wr(12'h018, 32'h1, 4'hF);
      wr(12'h01C, 32'h3, 4'hF);
      wr(12'h004, 32'h1, 4'hF);
      wait_tick(n);
      chk("oneshot_period", 32'(n), 32'd8);
      peek(12'h010, 32'h8000_0000, "oneshot_status");
      peek(12'h004, 32'h0, "oneshot_en_clr");
      peek(12'h020, 32'h0, "oneshot_count");
      wr(12'h010, 32'h8000_0000, 4'hF);

      // auto-reload, then reload value changed mid-run
      wr(12'h014, 32'h8000_0000, 4'hF);
      wr(12'h01C, 32'h3, 4'hF);
      wr(12'h004, 32'h3, 4'hF);
      wait_tick(n);
      chk("reload_period1", 32'(n), 32'd8);
      peek(12'h020, 32'h3, "reload_count");
      wait_tick(n);
      chk("reload_period2", 32'(n), 32'd8);
      repeat (3) cycle();
      wr(12'h01C, 32'h5, 4'hF);
      peek(12'h020, 32'h5, "load_restart");
      wait_tick(n);
      chk("load5_period", 32'(n), 32'd12);
      cycle();
      chk("irq_timer", 32'(irq), 32'd1);

      // reset while running with a pending interrupt
      aresetn = 1'b0;
      cycle();
      aresetn = 1'b1;
      chk("irq_after_rst", 32'(irq), 32'd0);
      chk("tick_after_rst", 32'(timer_tick), 32'd0);
      peek(12'h004, 32'h0, "ctrl_after_rst");
      peek(12'h010, 32'h0, "status_after_rst");
      peek(12'h020, 32'h0, "count_after_rst");
      cycle();
      peek(12'h014, 32'h0, "enable_after_rst");
      peek(12'h01C, 32'h0, "load_after_rst");
      peek(12'h018, 32'h0, "prescale_after_rst");
      acc = 1'b0;
      repeat (20) begin
         cycle();
         acc = acc | timer_tick;
      end
      chk("no_tick_after_rst", 32'(acc), 32'd0);

      // randomized traffic
      repeat (4000) begin
         wr_req = ($urandom_range(0, 99) < 40);
         rd_req = 1'($urandom);
         a = 12'($urandom);
         waddr = ($urandom_range(0, 9) != 0) ?
                 {a[11:6] & 6'h0, 4'($urandom_range(0, 9)), a[1:0]} : a;
         a = 12'($urandom);
         raddr = ($urandom_range(0, 9) != 0) ?
                 {a[11:6] & 6'h0, 4'($urandom_range(0, 9)), a[1:0]} : a;
         wstrb = 4'($urandom);
         wdata = ($urandom_range(0, 1) != 0) ?
                 32'($urandom_range(0, 6)) : $urandom;
         if ($urandom_range(0, 7) == 0) event_in = 4'($urandom);
         aresetn = ($urandom_range(0, 499) != 0);
         cycle();
      end
      aresetn = 1'b1;
      wr_req  = 1'b0;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
